// File: rtl/atm_pkg.sv
// Shared ATM constants: operation codes, control-FSM state codes and datapath widths.
// Optional build macro ATM_PIN_LOCKOUT_EN is consumed by atm_authenticator.
package atm_pkg;

    localparam int ACC_W = 4;
    localparam int PIN_W = 16;
    localparam int AMT_W = 32;

    // Operation codes share encoding with the matching control-FSM operation states.
    localparam logic [2:0] OP_BALANCE    = 3'd3;
    localparam logic [2:0] OP_WITHDRAW   = 3'd4;
    localparam logic [2:0] OP_DEPOSIT    = 3'd5;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAITING    = 3'd1;
    localparam logic [2:0] ST_MENU       = 3'd2;
    localparam logic [2:0] ST_BALANCE    = 3'd3;
    localparam logic [2:0] ST_WITHDRAW   = 3'd4;
    localparam logic [2:0] ST_DEPOSIT    = 3'd5;
    localparam logic [2:0] ST_CHANGE_PIN = 3'd6;

    typedef struct packed {
        logic [AMT_W-1:0] balance;
        logic             success;
        logic             bal_wr;
        logic             pin_wr;
    } op_result_t;

endpackage

// File: rtl/atm_authenticator.sv
// PIN table with combinational account lookup/authentication and a PIN write port.
// Latency: lookup 0 cycles, PIN write visible next cycle. No backpressure.
// ATM_PIN_LOCKOUT_EN adds per-account failure counters that lock after 3 bad PINs.
module atm_authenticator
    import atm_pkg::*;
#(
    parameter int unsigned      NUM_ACCOUNTS = 10,
    parameter logic [PIN_W-1:0] PIN_BASE     = 16'h1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             pin_wr,
    input  logic [PIN_W-1:0] new_pin,
    output logic [ACC_W-1:0] acc_index,
    output logic             acc_found,
    output logic             acc_auth
);

    logic [PIN_W-1:0] pin_tbl [NUM_ACCOUNTS];
    logic             pin_match;

    assign acc_found = 32'(acc_num) < NUM_ACCOUNTS;
    assign acc_index = acc_found ? acc_num : '0;
    assign pin_match = acc_found && (pin == pin_tbl[acc_index]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_ACCOUNTS); i++)
                pin_tbl[i] <= PIN_BASE + PIN_W'(i);
        end else if (pin_wr) begin
            pin_tbl[acc_index] <= new_pin;
        end
    end

`ifdef ATM_PIN_LOCKOUT_EN
    logic [1:0] fail_cnt [NUM_ACCOUNTS];
    logic       locked;

    assign locked   = (fail_cnt[acc_index] == 2'd3);
    assign acc_auth = pin_match && !locked;

    // Counter freezes once locked; only reset unlocks the account.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_ACCOUNTS); i++)
                fail_cnt[i] <= 2'd0;
        end else if (op_valid && acc_found && !locked) begin
            if (pin_match)
                fail_cnt[acc_index] <= 2'd0;
            else
                fail_cnt[acc_index] <= fail_cnt[acc_index] + 2'd1;
        end
    end
`else
    logic unused_op_valid;
    assign unused_op_valid = op_valid;
    assign acc_auth        = pin_match;
`endif

endmodule

// File: rtl/atm_account_engine.sv
// ATM account datapath: authentication plus balance/withdraw/deposit/PIN-change ops.
// Latency: one op per op_valid, results and done registered one cycle later. No backpressure.
// Build macro ATM_PIN_LOCKOUT_EN enables PIN lockout in atm_authenticator.
module atm_account_engine
    import atm_pkg::*;
#(
    parameter int unsigned      NUM_ACCOUNTS = 10,
    parameter logic [AMT_W-1:0] INIT_BALANCE = 32'd1000,
    parameter logic [PIN_W-1:0] PIN_BASE     = 16'h1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       operation,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] new_pin,
    input  logic [AMT_W-1:0] amount,
    output logic [ACC_W-1:0] acc_index,
    output logic             acc_found,
    output logic             acc_auth,
    output logic [AMT_W-1:0] balance,
    output logic             success,
    output logic             done
);

    logic [AMT_W-1:0] bal_tbl [NUM_ACCOUNTS];
    logic [AMT_W-1:0] stored;
    logic [AMT_W:0]   dep_sum;
    op_result_t       res;

    atm_authenticator #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .PIN_BASE     (PIN_BASE)
    ) u_auth (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .acc_num   (acc_num),
        .pin       (pin),
        .pin_wr    (op_valid && res.pin_wr),
        .new_pin   (new_pin),
        .acc_index (acc_index),
        .acc_found (acc_found),
        .acc_auth  (acc_auth)
    );

    assign stored  = bal_tbl[acc_index];
    assign dep_sum = {1'b0, stored} + {1'b0, amount};

    always_comb begin
        res.balance = stored;
        res.success = 1'b0;
        res.bal_wr  = 1'b0;
        res.pin_wr  = 1'b0;
        if (!acc_auth) begin
            res.balance = '0;
        end else begin
            case (operation)
                OP_BALANCE: res.success = 1'b1;
                OP_WITHDRAW: begin
                    if (amount <= stored) begin
                        res.balance = stored - amount;
                        res.success = 1'b1;
                        res.bal_wr  = 1'b1;
                    end
                end
                OP_DEPOSIT: begin
                    // Carry-out means the result would wrap; reject without touching the table.
                    if (!dep_sum[AMT_W]) begin
                        res.balance = dep_sum[AMT_W-1:0];
                        res.success = 1'b1;
                        res.bal_wr  = 1'b1;
                    end
                end
                OP_CHANGE_PIN: begin
                    res.success = 1'b1;
                    res.pin_wr  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_ACCOUNTS); i++)
                bal_tbl[i] <= INIT_BALANCE;
            balance <= '0;
            success <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= op_valid;
            if (op_valid) begin
                balance <= res.balance;
                success <= res.success;
                if (res.bal_wr)
                    bal_tbl[acc_index] <= res.balance;
            end
        end
    end

endmodule

// File: tb/tb_atm_account_engine.sv
module tb_atm_account_engine;
    import atm_pkg::*;

    logic             clk;
    logic             rst;
    logic             op_valid;
    logic [2:0]       operation;
    logic [ACC_W-1:0] acc_num;
    logic [PIN_W-1:0] pin;
    logic [PIN_W-1:0] new_pin;
    logic [AMT_W-1:0] amount;
    logic [ACC_W-1:0] acc_index;
    logic             acc_found;
    logic             acc_auth;
    logic [AMT_W-1:0] balance;
    logic             success;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    atm_account_engine dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .new_pin   (new_pin),
        .amount    (amount),
        .acc_index (acc_index),
        .acc_found (acc_found),
        .acc_auth  (acc_auth),
        .balance   (balance),
        .success   (success),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns #1 after the sampling edge so registered results are visible.
    task automatic do_op(input logic [3:0] a, input logic [15:0] p, input logic [2:0] o,
                         input logic [31:0] m, input logic [15:0] np);
        acc_num   = a;
        pin       = p;
        operation = o;
        amount    = m;
        new_pin   = np;
        op_valid  = 1'b1;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; op_valid = 1'b0; operation = 3'd0; acc_num = 4'd0;
        pin = 16'h0; new_pin = 16'h0; amount = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_balance", balance, 32'd0);
        chk("rst_success", {31'd0, success}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        idle_cycle();

        acc_num = 4'd3; pin = 16'h1003; #1;
        chk("lk3_found", {31'd0, acc_found}, 32'd1);
        chk("lk3_index", {28'd0, acc_index}, 32'd3);
        chk("lk3_auth", {31'd0, acc_auth}, 32'd1);
        pin = 16'h1004; #1;
        chk("lk3_badpin_auth", {31'd0, acc_auth}, 32'd0);
        acc_num = 4'd12; pin = 16'h100C; #1;
        chk("lk12_found", {31'd0, acc_found}, 32'd0);
        chk("lk12_index", {28'd0, acc_index}, 32'd0);
        chk("lk12_auth", {31'd0, acc_auth}, 32'd0);

        do_op(4'd2, 16'h1002, OP_WITHDRAW, 32'd300, 16'h0);
        chk("wd300_bal", balance, 32'd700);
        chk("wd300_ok", {31'd0, success}, 32'd1);
        chk("wd300_done", {31'd0, done}, 32'd1);
        idle_cycle();
        chk("done_drop", {31'd0, done}, 32'd0);
        chk("bal_hold", balance, 32'd700);
        do_op(4'd2, 16'h1002, OP_WITHDRAW, 32'd701, 16'h0);
        chk("wd701_ok", {31'd0, success}, 32'd0);
        chk("wd701_bal", balance, 32'd700);
        do_op(4'd2, 16'h1002, OP_WITHDRAW, 32'd700, 16'h0);
        chk("wdall_bal", balance, 32'd0);
        chk("wdall_ok", {31'd0, success}, 32'd1);
        do_op(4'd2, 16'h1002, OP_WITHDRAW, 32'd0, 16'h0);
        chk("wd0_ok", {31'd0, success}, 32'd1);
        chk("wd0_bal", balance, 32'd0);

        do_op(4'd5, 16'h1005, OP_DEPOSIT, 32'd250, 16'h0);
        chk("dep250_bal", balance, 32'd1250);
        chk("dep250_ok", {31'd0, success}, 32'd1);
        do_op(4'd5, 16'h1005, OP_DEPOSIT, 32'hFFFF_FFFF, 16'h0);
        chk("depovf_ok", {31'd0, success}, 32'd0);
        chk("depovf_bal", balance, 32'd1250);

        // Back-to-back: op_valid held across two edges, second sees first's update.
        acc_num = 4'd5; pin = 16'h1005; operation = OP_WITHDRAW; amount = 32'd50;
        op_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b1_bal", balance, 32'd1200);
        chk("b2b1_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("b2b2_bal", balance, 32'd1150);
        chk("b2b2_done", {31'd0, done}, 32'd1);

        do_op(4'd1, 16'h1001, OP_CHANGE_PIN, 32'd0, 16'hBEEF);
        chk("cpin_ok", {31'd0, success}, 32'd1);
        chk("cpin_bal", balance, 32'd1000);
        acc_num = 4'd1; pin = 16'h1001; #1;
        chk("cpin_old_auth", {31'd0, acc_auth}, 32'd0);
        pin = 16'hBEEF; #1;
        chk("cpin_new_auth", {31'd0, acc_auth}, 32'd1);
        do_op(4'd1, 16'hBEEF, OP_BALANCE, 32'd0, 16'h0);
        chk("cpin_balq", balance, 32'd1000);
        chk("cpin_balq_ok", {31'd0, success}, 32'd1);

        do_op(4'd0, 16'h1234, OP_WITHDRAW, 32'd10, 16'h0);
        chk("badpin_ok", {31'd0, success}, 32'd0);
        chk("badpin_bal", balance, 32'd0);
        do_op(4'd0, 16'h1000, OP_BALANCE, 32'd0, 16'h0);
        chk("badpin_kept", balance, 32'd1000);
        do_op(4'd0, 16'h1000, 3'd7, 32'd5, 16'h0);
        chk("illegal_ok", {31'd0, success}, 32'd0);
        chk("illegal_bal", balance, 32'd1000);
        do_op(4'd2, 16'h1002, OP_BALANCE, 32'd0, 16'h0);
        chk("acct2_pre_rst", balance, 32'd0);

        #2 rst = 1'b0;
        #1;
        chk("arst_balance", balance, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(4'd2, 16'h1002, OP_BALANCE, 32'd0, 16'h0);
        chk("post_rst_acct2", balance, 32'd1000);
        do_op(4'd5, 16'h1005, OP_BALANCE, 32'd0, 16'h0);
        chk("post_rst_acct5", balance, 32'd1000);
        acc_num = 4'd1; pin = 16'h1001; #1;
        chk("post_rst_pin1", {31'd0, acc_auth}, 32'd1);

        for (int k = 0; k < 3; k++)
            do_op(4'd4, 16'h0BAD, OP_BALANCE, 32'd0, 16'h0);
        acc_num = 4'd4; pin = 16'h1004; #1;
`ifdef ATM_PIN_LOCKOUT_EN
        chk("lock_auth", {31'd0, acc_auth}, 32'd0);
        do_op(4'd4, 16'h1004, OP_BALANCE, 32'd0, 16'h0);
        chk("lock_bal_ok", {31'd0, success}, 32'd0);
        rst = 1'b0;
        idle_cycle();
        rst = 1'b1;
        idle_cycle();
        acc_num = 4'd4; pin = 16'h1004; #1;
        chk("unlock_auth", {31'd0, acc_auth}, 32'd1);
`else
        chk("nolock_auth", {31'd0, acc_auth}, 32'd1);
        do_op(4'd4, 16'h1004, OP_BALANCE, 32'd0, 16'h0);
        chk("nolock_bal_ok", {31'd0, success}, 32'd1);
        chk("nolock_bal", balance, 32'd1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
